// File: rtl/cla_serial_pkg.sv
// Shared constants and state encoding for the nibble-serial CLA adder.
package cla_serial_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/cla_serial_adder_add4.sv
// Existing 4-bit carry-lookahead adder slice; all carries computed in parallel
// from per-bit generate/propagate terms.
module Add4_head
    import cla_serial_pkg::*;
(
    input  logic [NIB_W-1:0] A,
    input  logic [NIB_W-1:0] B,
    input  logic             C_in,
    output logic [NIB_W-1:0] F,
    output logic             C_out,
    output logic             Gm,
    output logic             Pm
);

    logic [NIB_W-1:0] g;
    logic [NIB_W-1:0] p;
    logic [NIB_W-1:0] c;

    assign g = A & B;
    assign p = A ^ B;

    assign c[0] = C_in;
    assign c[1] = g[0] | (p[0] & C_in);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & C_in);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & C_in);

    // Group terms let a higher-level lookahead unit skip over this slice.
    assign Gm = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);
    assign Pm = &p;

    assign C_out = Gm | (Pm & C_in);
    assign F     = p ^ c;

endmodule

// File: rtl/cla_serial_adder.sv
// WIDTH-bit adder that reuses one 4-bit CLA slice over WIDTH/4 cycles,
// carrying between nibbles through a register.
module cla_serial_adder
    import cla_serial_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             busy
);

    localparam int NIB   = WIDTH / NIB_W;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [NIB_W-1:0] a_nib;
    logic [NIB_W-1:0] b_nib;
    logic [NIB_W-1:0] f_nib;
    logic             c_nib;

    assign a_nib = a_r[NIB_W*idx +: NIB_W];
    assign b_nib = b_r[NIB_W*idx +: NIB_W];

    Add4_head u_add4 (
        .A     (a_nib),
        .B     (b_nib),
        .C_in  (carry),
        .F     (f_nib),
        .C_out (c_nib),
        .Gm    (),
        .Pm    ()
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            carry <= 1'b0;
            a_r   <= '0;
            b_r   <= '0;
            sum   <= '0;
            c_out <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= b;
                        carry <= c_in;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum[NIB_W*idx +: NIB_W] <= f_nib;
                    carry <= c_nib;
                    if (idx == LAST_IDX) begin
                        c_out <= c_nib;
                        // Carry into the MSB is recovered from the MSB sum bit.
                        ovf   <= a_nib[NIB_W-1] ^ b_nib[NIB_W-1] ^ f_nib[NIB_W-1] ^ c_nib;
                        idx   <= '0;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_serial_adder.sv
// Scoreboard bench for the nibble-serial adder at WIDTH=16, plus a WIDTH=8 instance.
module tb_cla_serial_adder;

    typedef struct packed {
        logic [15:0] sum;
        logic        c_out;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [15:0] a, b, sum;
    logic        c_in, c_out, ovf;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
    logic [7:0]  a8, b8, sum8;
    logic        c_in8, c_out8, ovf8;

    exp_t        sbq[$];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    cla_serial_adder #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .c_out(c_out), .ovf(ovf), .busy(busy)
    );

    cla_serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .c_in(c_in8), .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .c_out(c_out8), .ovf(ovf8), .busy(busy8)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model16(input logic [15:0] av, input logic [15:0] bv, input logic ci);
        logic [16:0] full;
        exp_t        e;
        full    = {1'b0, av} + {1'b0, bv} + {16'd0, ci};
        e.sum   = full[15:0];
        e.c_out = full[16];
        e.ovf   = (av[15] == bv[15]) && (full[15] != av[15]);
        return e;
    endfunction

    // Waits for in_ready, presents one operand pair, then waits for out_valid.
    task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv, input logic ci);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("in_ready_wait", {31'd0, in_ready}, 32'd1);
        checkOutput("out_valid_idle", {31'd0, out_valid}, 32'd0);
        a        = av;
        b        = bv;
        c_in     = ci;
        in_valid = 1'b1;
        sbq.push_back(model16(av, bv, ci));
        @(negedge clk);
        in_valid = 1'b0;
        a        = ~av;
        b        = ~bv;
        n = 0;
        while (!out_valid && n < 50) begin
            checkOutput("in_ready_run", {31'd0, in_ready}, 32'd0);
            checkOutput("busy_run", {31'd0, busy}, 32'd1);
            @(negedge clk);
            n++;
        end
        checkOutput("latency16", n, 32'd4);
    endtask

    // Pops the expected result, optionally stalls the consumer, then retires it.
    task automatic drainResult(input int hold, input logic [15:0] hold_a);
        exp_t e;
        if (sbq.size() == 0) begin
            checkOutput("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = sbq.pop_front();
        checkOutput("out_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("sum", {16'd0, sum}, {16'd0, e.sum});
        checkOutput("c_out", {31'd0, c_out}, {31'd0, e.c_out});
        checkOutput("ovf", {31'd0, ovf}, {31'd0, e.ovf});
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            a         = hold_a;
            b         = 16'h1111;
            @(negedge clk);
            checkOutput("hold_sum", {16'd0, sum}, {16'd0, e.sum});
            checkOutput("hold_c_out", {31'd0, c_out}, {31'd0, e.c_out});
            checkOutput("hold_ovf", {31'd0, ovf}, {31'd0, e.ovf});
            checkOutput("hold_in_ready", {31'd0, in_ready}, 32'd0);
            checkOutput("hold_out_valid", {31'd0, out_valid}, 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("retire_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("retire_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("retire_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic runOp8(input logic [7:0] av, input logic [7:0] bv, input logic ci);
        logic [8:0] full;
        int         n;
        full      = {1'b0, av} + {1'b0, bv} + {8'd0, ci};
        a8        = av;
        b8        = bv;
        c_in8     = ci;
        in_valid8 = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0;
        n = 0;
        while (!out_valid8 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("latency8", n, 32'd2);
        checkOutput("sum8", {24'd0, sum8}, {24'd0, full[7:0]});
        checkOutput("c_out8", {31'd0, c_out8}, {31'd0, full[8]});
        checkOutput("ovf8", {31'd0, ovf8},
                    {31'd0, (av[7] == bv[7]) && (full[7] != av[7])});
        out_ready8 = 1'b1;
        @(negedge clk);
        out_ready8 = 1'b0;
        checkOutput("retire8_in_ready", {31'd0, in_ready8}, 32'd1);
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        a          = '0;
        b          = '0;
        c_in       = 1'b0;
        in_valid8  = 1'b0;
        out_ready8 = 1'b0;
        a8         = '0;
        b8         = '0;
        c_in8      = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_sum", {16'd0, sum}, 32'd0);
        checkOutput("rst_c_out", {31'd0, c_out}, 32'd0);
        checkOutput("rst_ovf", {31'd0, ovf}, 32'd0);
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(16'h1234, 16'h4321, 1'b0);
        drainResult(0, 16'h0000);
        applyStimulus(16'hFFFF, 16'h0001, 1'b0);
        drainResult(0, 16'h0000);
        applyStimulus(16'h7FFF, 16'h0001, 1'b0);
        drainResult(0, 16'h0000);
        applyStimulus(16'h8000, 16'h8000, 1'b1);
        drainResult(5, 16'hAAAA);
        applyStimulus(16'hAAAA, 16'h1111, 1'b0);
        drainResult(0, 16'h0000);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(16'($urandom), 16'($urandom), 1'($urandom));
            drainResult(int'($urandom_range(0, 2)), 16'($urandom));
        end

        // Abort an addition two nibbles in; no result may surface.
        a        = 16'hFFFF;
        b        = 16'h0001;
        c_in     = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("abort_sum", {16'd0, sum}, 32'd0);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            checkOutput("abort_no_valid", {31'd0, out_valid}, 32'd0);
        end
        applyStimulus(16'h0003, 16'h0004, 1'b0);
        drainResult(0, 16'h0000);

        runOp8(8'hF0, 8'h10, 1'b0);
        runOp8(8'h7F, 8'h01, 1'b0);
        runOp8(8'h3C, 8'h42, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
